// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel synchroniser plus stability-counter debouncer
// producing a clean level and single-cycle rise/fall pulses.
module debouncer_multi #(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter int   MODE          = 0,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_en,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out, r_rise, r_fall;
    logic                   w_s, w_fast_fall, w_accept, w_clear;
    assign w_s         = r_sync[SYNC_STAGES-1];
    // press-only mode drops the level as soon as the synchronised input is low
    assign w_fast_fall = (MODE == 1) && !w_s && r_out;
    assign w_accept    = (w_s != r_out) && sample_en && (r_cnt == CNT_MAX);
    assign w_clear     = w_fast_fall || (w_s == r_out) || w_accept;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_sync <= {SYNC_STAGES{RESET_VAL}};
        r_cnt  <= '0;
        r_out  <= RESET_VAL;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[c]};
        r_rise <= w_accept && w_s;
        r_fall <= w_fast_fall || (w_accept && !w_s);
        r_out  <= (w_fast_fall || w_accept) ? w_s : r_out;
        r_cnt  <= w_clear ? '0 : sample_en ? r_cnt + 1'b1 : r_cnt;
      end
    assign btn_out[c] = r_out;
    assign rise[c]    = r_rise;
    assign fall[c]    = r_fall;
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: symmetric and press-only instances driven in parallel;
// expected pulses are queued by the stimulus and matched by a monitor.
module tb_debouncer_multi;
  typedef struct packed {
    int         c;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] o;
  } ev_t;
  logic       clk = 1'b0;
  logic       reset;
  logic       gate;
  logic       sample_en;
  logic [3:0] btn_in;
  logic [3:0] o0, r0, f0, o1, r1, f1;
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  ev_t        q0[$];
  ev_t        q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sample_en = gate ? (cyc % 4 == 3) : 1'b1;
  debouncer_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .MODE(0), .RESET_VAL(1'b0)) d0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .btn_in(btn_in),
    .btn_out(o0), .rise(r0), .fall(f0));
  debouncer_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .MODE(1), .RESET_VAL(1'b0)) d1 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .btn_in(btn_in),
    .btn_out(o1), .rise(r1), .fall(f1));
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask
  task automatic exp_ev(input int d, input int c, input logic [3:0] r, f, o);
    ev_t e;
    e = '{c: c, r: r, f: f, o: o};
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic exp_both(input int c0, input int c1, input logic [3:0] r, f, o);
    exp_ev(0, c0, r, f, o);
    exp_ev(1, c1, r, f, o);
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev_t e;
      logic [3:0] gr, gf, go;
      bit have;
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      e = '0;
      if (have) e = (d == 0) ? q0[0] : q1[0];
      gr = (d == 0) ? r0 : r1;
      gf = (d == 0) ? f0 : f1;
      go = (d == 0) ? o0 : o1;
      if ((gr | gf) != 4'b0 || (have && e.c < cyc)) begin
        total++;
        if (!have)
          $display("FAIL spurious dut%0d: cyc=%0d rise=%b fall=%b out=%b, expected no pulse", d, cyc, gr, gf, go);
        else begin
          if (e.c == cyc && e.r == gr && e.f == gf && e.o == go) passed++;
          else $display("FAIL event dut%0d: got cyc=%0d rise=%b fall=%b out=%b, expected cyc=%0d rise=%b fall=%b out=%b",
                        d, cyc, gr, gf, go, e.c, e.r, e.f, e.o);
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  end
  initial begin
    int c;
    gate = 1'b0;
    btn_in = 4'hF;
    reset = 1'b1;
    #1 reset = 1'b0;
    wait_n(3);
    chk("rst_out0", int'(o0), 0);
    chk("rst_out1", int'(o1), 0);
    chk("rst_pulse0", int'(r0 | f0), 0);
    chk("rst_pulse1", int'(r1 | f1), 0);
    btn_in = 4'h0;
    reset = 1'b1;
    wait_n(10);
    c = cyc;
    btn_in[0] = 1'b1;
    exp_both(c + 6, c + 6, 4'b0001, 4'b0000, 4'b0001);
    wait_n(5);
    chk("press_early", int'(o0), 0);
    wait_n(5);
    btn_in[1] = 1'b1; wait_n(3);
    btn_in[1] = 1'b0; wait_n(1);
    btn_in[1] = 1'b1; wait_n(3);
    btn_in[1] = 1'b0; wait_n(10);
    chk("bounce0", int'(o0), 4'b0001);
    chk("bounce1", int'(o1), 4'b0001);
    c = cyc;
    btn_in[2] = 1'b1;
    exp_both(c + 6, c + 6, 4'b0100, 4'b0000, 4'b0101);
    wait_n(10);
    c = cyc;
    btn_in[2] = 1'b0;
    exp_both(c + 6, c + 3, 4'b0000, 4'b0100, 4'b0001);
    wait_n(10);
    gate = 1'b1;
    wait_n(4);
    while (cyc % 4 != 0) wait_n(1);
    c = cyc;
    btn_in[3] = 1'b1;
    exp_both(c + 16, c + 16, 4'b1000, 4'b0000, 4'b1001);
    wait_n(20);
    c = cyc;
    btn_in[1] = 1'b1; wait_n(2);
    btn_in[1] = 1'b0; wait_n(4);
    btn_in[1] = 1'b1;
    exp_both(c + 24, c + 24, 4'b0010, 4'b0000, 4'b1011);
    wait_n(17);
    chk("gate_hold", int'(o0), 4'b1001);
    wait_n(5);
    gate = 1'b0;
    wait_n(4);
    c = cyc;
    btn_in = 4'b0000;
    exp_both(c + 6, c + 3, 4'b0000, 4'b1011, 4'b0000);
    wait_n(10);
    c = cyc;
    btn_in = 4'b1001;
    exp_both(c + 6, c + 6, 4'b1001, 4'b0000, 4'b1001);
    wait_n(10);
    c = cyc;
    btn_in = 4'b0000;
    exp_both(c + 6, c + 3, 4'b0000, 4'b1001, 4'b0000);
    wait_n(10);
    btn_in = 4'b1001;
    wait_n(4);
    reset = 1'b0;
    wait_n(2);
    chk("midrst_out0", int'(o0), 0);
    chk("midrst_out1", int'(o1), 0);
    c = cyc;
    reset = 1'b1;
    exp_both(c + 6, c + 6, 4'b1001, 4'b0000, 4'b1001);
    wait_n(5);
    chk("post_rst_early", int'(o0), 0);
    wait_n(5);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
